core_writeback: RTL and testbench

- Consumer end of the dual-issue dispatch interface.
- Tracks per-unit pending destination registers, driven by the start_* pulses and decodes that dispatch produces.
- Collects results from ALU A, ALU B, mul, ldst and branch, and drives the two register-file write ports.
- Returns the hword pending masks and the per-unit writeback stalls to dispatch and the execution units.

---
 rtl/core_writeback_pkg.sv | 48 ++++
 rtl/core_wb_queue.sv | 58 +++++
 rtl/core_writeback.sv | 211 +++++++++++++++++++++
 tb/tb_core_writeback.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_writeback_pkg.sv
`default_nettype none
// ============================================================================
// Package  : core_writeback_pkg
// Brief    : Shared types for the writeback stage: decode view, result tags
//            and queue entries.
// Revision : 1.0 - initial release
// ============================================================================
package core_writeback_pkg;

  localparam int c_WORD_BITS = 32;
  localparam int c_NUM_REGS  = 16;

  typedef logic [c_WORD_BITS-1:0]         word;
  typedef logic [c_NUM_REGS-1:0]          hword;
  typedef logic [$clog2(c_NUM_REGS)-1:0]  reg_num;

  // Only the decode fields the writeback stage consumes
  typedef struct packed {
    reg_num rd;
  } insn_data;

  typedef struct packed {
    logic writeback;
  } insn_ctrl;

  typedef struct packed {
    insn_data data;
    insn_ctrl ctrl;
  } insn_decode;

  typedef enum logic [1:0] {
    WB_MUL    = 2'd0,
    WB_LDST   = 2'd1,
    WB_BRANCH = 2'd2
  } wb_unit;

  typedef struct packed {
    wb_unit unit;
    reg_num r;
    word    value;
  } wb_entry;

  function automatic hword reg_onehot(input reg_num r);
    reg_onehot = hword'(1) << r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/core_wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : core_wb_queue
// Brief    : Synchronous FIFO of wb_entry holding accepted single-unit results.
// Revision : 1.0 - initial release
// ============================================================================
module core_wb_queue
  import core_writeback_pkg::*;
#(
  parameter int QUEUE_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  wb_entry                      push_data,
  input  logic                         pop,
  output wb_entry                      head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(QUEUE_DEPTH):0] count
);

  localparam int c_PTR_W = $clog2(QUEUE_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  wb_entry              r_mem [QUEUE_DEPTH];
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_CNT_W-1:0]   r_count;

  // Depth is a power of two, so pointers wrap by plain overflow
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({push, pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= push_data;
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign full  = (r_count == c_CNT_W'(QUEUE_DEPTH));
  assign empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/core_writeback.sv
`default_nettype none
// ============================================================================
// Module   : core_writeback
// Brief    : Writeback stage: pending-register masks, single-unit result
//            arbitration/queueing and the two register-file write ports.
// Options  : CORE_WB_FORWARD_EN - accepted single results bypass an empty
//            queue onto a free write port (latency 1 instead of 2).
// Revision : 1.0 - initial release
// ============================================================================
module core_writeback
  import core_writeback_pkg::*;
#(
  parameter int QUEUE_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_alu_a,
  input  logic       start_alu_b,
  input  logic       start_mul,
  input  logic       start_ldst,
  input  logic       start_branch,
  input  insn_decode dec_alu_a,
  input  insn_decode dec_alu_b,
  input  insn_decode dec_single,
  input  logic       alu_a_valid,
  input  logic       alu_b_valid,
  input  word        alu_a_value,
  input  word        alu_b_value,
  input  reg_num     alu_a_rd,
  input  reg_num     alu_b_rd,
  input  logic       mul_valid,
  input  logic       ldst_valid,
  input  logic       branch_valid,
  input  word        mul_value,
  input  word        ldst_value,
  input  word        branch_value,
  input  reg_num     mul_rd,
  input  reg_num     ldst_rd,
  input  reg_num     branch_rd,
  output logic       wb_stall_mul,
  output logic       wb_stall_ldst,
  output logic       wb_stall_branch,
  output hword       mask_alu_a,
  output hword       mask_alu_b,
  output hword       mask_mul,
  output hword       mask_ldst,
  output hword       mask_branch,
  output logic       wr_en_a,
  output logic       wr_en_b,
  output reg_num     wr_r_a,
  output reg_num     wr_r_b,
  output word        wr_value_a,
  output word        wr_value_b
);

  localparam int c_CNT_W = $clog2(QUEUE_DEPTH) + 1;

  wb_entry            w_head;
  logic               w_full;
  logic               w_empty;
  logic [c_CNT_W-1:0] w_count;

  logic    w_drain_a;
  logic    w_drain_b;
  logic    w_drain;
  logic    w_room;
  logic    w_acc_mul;
  logic    w_acc_ldst;
  logic    w_acc_branch;
  logic    w_acc_any;
  wb_entry w_acc_entry;
  logic    w_fwd_a;
  logic    w_fwd_b;
  logic    w_push;

  wb_entry w_retire;
  logic    w_retire_v;

  hword w_set_alu_a, w_set_alu_b, w_set_mul, w_set_ldst, w_set_branch;
  hword w_clr_alu_a, w_clr_alu_b, w_clr_mul, w_clr_ldst, w_clr_branch;

  hword   r_mask_alu_a, r_mask_alu_b, r_mask_mul, r_mask_ldst, r_mask_branch;
  logic   r_wr_en_a, r_wr_en_b;
  reg_num r_wr_r_a, r_wr_r_b;
  word    r_wr_value_a, r_wr_value_b;

  core_wb_queue #(
    .QUEUE_DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (w_acc_entry),
    .pop       (w_drain),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  // ALU results own their port; the queue head takes whichever port is idle
  assign w_drain_a = !w_empty && !alu_a_valid;
  assign w_drain_b = !w_empty && alu_a_valid && !alu_b_valid;
  assign w_drain   = w_drain_a || w_drain_b;

  // A full queue still accepts when its head leaves in the same cycle
  assign w_room = (w_count < c_CNT_W'(QUEUE_DEPTH)) || (w_full && w_drain);

  assign w_acc_branch = branch_valid && w_room;
  assign w_acc_ldst   = ldst_valid && !branch_valid && w_room;
  assign w_acc_mul    = mul_valid && !ldst_valid && !branch_valid && w_room;
  assign w_acc_any    = w_acc_mul || w_acc_ldst || w_acc_branch;

  always_comb begin
    w_acc_entry = '{unit: WB_MUL, r: mul_rd, value: mul_value};
    if (branch_valid)
      w_acc_entry = '{unit: WB_BRANCH, r: branch_rd, value: branch_value};
    else if (ldst_valid)
      w_acc_entry = '{unit: WB_LDST, r: ldst_rd, value: ldst_value};
  end

`ifdef CORE_WB_FORWARD_EN
  assign w_fwd_a = w_acc_any && w_empty && !alu_a_valid;
  assign w_fwd_b = w_acc_any && w_empty && alu_a_valid && !alu_b_valid;
`else
  assign w_fwd_a = 1'b0;
  assign w_fwd_b = 1'b0;
`endif

  assign w_push = w_acc_any && !(w_fwd_a || w_fwd_b);

  assign wb_stall_mul    = mul_valid && !w_acc_mul;
  assign wb_stall_ldst   = ldst_valid && !w_acc_ldst;
  assign wb_stall_branch = branch_valid && !w_acc_branch;

  // The single result reaching a port this cycle, queued or bypassed
  assign w_retire_v = w_drain || w_fwd_a || w_fwd_b;
  assign w_retire   = w_drain ? w_head : w_acc_entry;

  always_comb begin
    w_set_alu_a  = (start_alu_a  && dec_alu_a.ctrl.writeback)  ? reg_onehot(dec_alu_a.data.rd)  : '0;
    w_set_alu_b  = (start_alu_b  && dec_alu_b.ctrl.writeback)  ? reg_onehot(dec_alu_b.data.rd)  : '0;
    w_set_mul    = (start_mul    && dec_single.ctrl.writeback) ? reg_onehot(dec_single.data.rd) : '0;
    w_set_ldst   = (start_ldst   && dec_single.ctrl.writeback) ? reg_onehot(dec_single.data.rd) : '0;
    w_set_branch = (start_branch && dec_single.ctrl.writeback) ? reg_onehot(dec_single.data.rd) : '0;
    w_clr_alu_a  = alu_a_valid ? reg_onehot(alu_a_rd) : '0;
    w_clr_alu_b  = alu_b_valid ? reg_onehot(alu_b_rd) : '0;
    w_clr_mul    = (w_retire_v && w_retire.unit == WB_MUL)    ? reg_onehot(w_retire.r) : '0;
    w_clr_ldst   = (w_retire_v && w_retire.unit == WB_LDST)   ? reg_onehot(w_retire.r) : '0;
    w_clr_branch = (w_retire_v && w_retire.unit == WB_BRANCH) ? reg_onehot(w_retire.r) : '0;
  end

  // Set is OR-ed after the clear so a re-dispatch keeps the bit pending
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mask_alu_a  <= '0;
      r_mask_alu_b  <= '0;
      r_mask_mul    <= '0;
      r_mask_ldst   <= '0;
      r_mask_branch <= '0;
    end else begin
      r_mask_alu_a  <= (r_mask_alu_a  & ~w_clr_alu_a)  | w_set_alu_a;
      r_mask_alu_b  <= (r_mask_alu_b  & ~w_clr_alu_b)  | w_set_alu_b;
      r_mask_mul    <= (r_mask_mul    & ~w_clr_mul)    | w_set_mul;
      r_mask_ldst   <= (r_mask_ldst   & ~w_clr_ldst)   | w_set_ldst;
      r_mask_branch <= (r_mask_branch & ~w_clr_branch) | w_set_branch;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_en_a <= 1'b0;
      r_wr_en_b <= 1'b0;
    end else begin
      r_wr_en_a <= alu_a_valid || w_drain_a || w_fwd_a;
      r_wr_en_b <= alu_b_valid || w_drain_b || w_fwd_b;
    end
  end

  // Address/data are meaningful only alongside wr_en, so they carry no reset
  always_ff @(posedge clk) begin
    if (alu_a_valid) begin
      r_wr_r_a     <= alu_a_rd;
      r_wr_value_a <= alu_a_value;
    end else if (w_drain_a || w_fwd_a) begin
      r_wr_r_a     <= w_retire.r;
      r_wr_value_a <= w_retire.value;
    end
    if (alu_b_valid) begin
      r_wr_r_b     <= alu_b_rd;
      r_wr_value_b <= alu_b_value;
    end else if (w_drain_b || w_fwd_b) begin
      r_wr_r_b     <= w_retire.r;
      r_wr_value_b <= w_retire.value;
    end
  end

  assign mask_alu_a  = r_mask_alu_a;
  assign mask_alu_b  = r_mask_alu_b;
  assign mask_mul    = r_mask_mul;
  assign mask_ldst   = r_mask_ldst;
  assign mask_branch = r_mask_branch;
  assign wr_en_a     = r_wr_en_a;
  assign wr_en_b     = r_wr_en_b;
  assign wr_r_a      = r_wr_r_a;
  assign wr_r_b      = r_wr_r_b;
  assign wr_value_a  = r_wr_value_a;
  assign wr_value_b  = r_wr_value_b;

endmodule
`default_nettype wire

// File: tb/tb_core_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_writeback
// Brief    : Directed self-checking bench for core_writeback with a queue-based
//            reference model; honours CORE_WB_FORWARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_writeback;
  import core_writeback_pkg::*;

  localparam int DEPTH = 2;

  logic clk;
  logic rst_n;
  logic start_alu_a, start_alu_b, start_mul, start_ldst, start_branch;
  insn_decode dec_alu_a, dec_alu_b, dec_single;
  logic alu_a_valid, alu_b_valid;
  word alu_a_value, alu_b_value;
  reg_num alu_a_rd, alu_b_rd;
  logic mul_valid, ldst_valid, branch_valid;
  word mul_value, ldst_value, branch_value;
  reg_num mul_rd, ldst_rd, branch_rd;
  logic wb_stall_mul, wb_stall_ldst, wb_stall_branch;
  hword mask_alu_a, mask_alu_b, mask_mul, mask_ldst, mask_branch;
  logic wr_en_a, wr_en_b;
  reg_num wr_r_a, wr_r_b;
  word wr_value_a, wr_value_b;

  core_writeback #(.QUEUE_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_alu_a(start_alu_a), .start_alu_b(start_alu_b), .start_mul(start_mul),
    .start_ldst(start_ldst), .start_branch(start_branch),
    .dec_alu_a(dec_alu_a), .dec_alu_b(dec_alu_b), .dec_single(dec_single),
    .alu_a_valid(alu_a_valid), .alu_b_valid(alu_b_valid),
    .alu_a_value(alu_a_value), .alu_b_value(alu_b_value),
    .alu_a_rd(alu_a_rd), .alu_b_rd(alu_b_rd),
    .mul_valid(mul_valid), .ldst_valid(ldst_valid), .branch_valid(branch_valid),
    .mul_value(mul_value), .ldst_value(ldst_value), .branch_value(branch_value),
    .mul_rd(mul_rd), .ldst_rd(ldst_rd), .branch_rd(branch_rd),
    .wb_stall_mul(wb_stall_mul), .wb_stall_ldst(wb_stall_ldst), .wb_stall_branch(wb_stall_branch),
    .mask_alu_a(mask_alu_a), .mask_alu_b(mask_alu_b), .mask_mul(mask_mul),
    .mask_ldst(mask_ldst), .mask_branch(mask_branch),
    .wr_en_a(wr_en_a), .wr_en_b(wr_en_b), .wr_r_a(wr_r_a), .wr_r_b(wr_r_b),
    .wr_value_a(wr_value_a), .wr_value_b(wr_value_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic insn_decode mk_dec(input reg_num r, input logic wb);
    insn_decode d;
    d.data.rd = r;
    d.ctrl.writeback = wb;
    return d;
  endfunction

  function automatic int uidx(input wb_unit u);
    case (u)
      WB_MUL:  return 2;
      WB_LDST: return 3;
      default: return 4;
    endcase
  endfunction

  // ---------------- reference model (mask index: aluA,aluB,mul,ldst,branch)
  logic    m_en_a, m_en_b;
  reg_num  m_r_a, m_r_b;
  word     m_v_a, m_v_b;
  hword    m_mask [5];
  wb_entry mq [$];
  bit      armed = 0;

  initial begin
    int n, sel;
    bit da, db, dr, acc, fa, fb;
    wb_entry cand, hd;
    forever begin
      @(negedge clk);
      n  = mq.size();
      da = (n > 0) && !alu_a_valid;
      db = (n > 0) && alu_a_valid && !alu_b_valid;
      dr = da || db;
      if (n > 0) hd = mq[0];
      sel = branch_valid ? 4 : ldst_valid ? 3 : mul_valid ? 2 : 0;
      case (sel)
        4:       cand = '{unit: WB_BRANCH, r: branch_rd, value: branch_value};
        3:       cand = '{unit: WB_LDST, r: ldst_rd, value: ldst_value};
        default: cand = '{unit: WB_MUL, r: mul_rd, value: mul_value};
      endcase
      acc = (sel != 0) && ((n < DEPTH) || dr);
      fa = 0;
      fb = 0;
`ifdef CORE_WB_FORWARD_EN
      if (acc && n == 0) begin
        fa = !alu_a_valid;
        fb = alu_a_valid && !alu_b_valid;
      end
`endif
      if (armed) begin
        chk("wr_en_a", wr_en_a, m_en_a);
        chk("wr_en_b", wr_en_b, m_en_b);
        if (m_en_a) begin chk("wr_r_a", wr_r_a, m_r_a); chk("wr_value_a", wr_value_a, m_v_a); end
        if (m_en_b) begin chk("wr_r_b", wr_r_b, m_r_b); chk("wr_value_b", wr_value_b, m_v_b); end
        chk("mask_alu_a", mask_alu_a, m_mask[0]);
        chk("mask_alu_b", mask_alu_b, m_mask[1]);
        chk("mask_mul", mask_mul, m_mask[2]);
        chk("mask_ldst", mask_ldst, m_mask[3]);
        chk("mask_branch", mask_branch, m_mask[4]);
        chk("wb_stall_mul", wb_stall_mul, mul_valid && !(acc && sel == 2));
        chk("wb_stall_ldst", wb_stall_ldst, ldst_valid && !(acc && sel == 3));
        chk("wb_stall_branch", wb_stall_branch, branch_valid && !(acc && sel == 4));
      end
      if (!rst_n) begin
        m_en_a = 0; m_en_b = 0;
        for (int i = 0; i < 5; i++) m_mask[i] = '0;
        mq.delete();
        armed = 1;
      end else if (armed) begin
        if (alu_a_valid)  begin m_en_a = 1; m_r_a = alu_a_rd; m_v_a = alu_a_value; end
        else if (da)      begin m_en_a = 1; m_r_a = hd.r; m_v_a = hd.value; end
        else if (fa)      begin m_en_a = 1; m_r_a = cand.r; m_v_a = cand.value; end
        else m_en_a = 0;
        if (alu_b_valid)  begin m_en_b = 1; m_r_b = alu_b_rd; m_v_b = alu_b_value; end
        else if (db)      begin m_en_b = 1; m_r_b = hd.r; m_v_b = hd.value; end
        else if (fb)      begin m_en_b = 1; m_r_b = cand.r; m_v_b = cand.value; end
        else m_en_b = 0;
        if (alu_a_valid) m_mask[0][alu_a_rd] = 1'b0;
        if (alu_b_valid) m_mask[1][alu_b_rd] = 1'b0;
        if (dr) m_mask[uidx(hd.unit)][hd.r] = 1'b0;
        if (fa || fb) m_mask[sel][cand.r] = 1'b0;
        if (start_alu_a  && dec_alu_a.ctrl.writeback)  m_mask[0][dec_alu_a.data.rd]  = 1'b1;
        if (start_alu_b  && dec_alu_b.ctrl.writeback)  m_mask[1][dec_alu_b.data.rd]  = 1'b1;
        if (start_mul    && dec_single.ctrl.writeback) m_mask[2][dec_single.data.rd] = 1'b1;
        if (start_ldst   && dec_single.ctrl.writeback) m_mask[3][dec_single.data.rd] = 1'b1;
        if (start_branch && dec_single.ctrl.writeback) m_mask[4][dec_single.data.rd] = 1'b1;
        if (dr) void'(mq.pop_front());
        if (acc && !(fa || fb)) mq.push_back(cand);
      end
    end
  end

  // ---------------- stimulus
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start_alu_a = 0; start_alu_b = 0; start_mul = 0; start_ldst = 0; start_branch = 0;
    dec_alu_a = '0; dec_alu_b = '0; dec_single = '0;
    alu_a_valid = 0; alu_b_valid = 0; alu_a_value = '0; alu_b_value = '0;
    alu_a_rd = '0; alu_b_rd = '0;
    mul_valid = 0; ldst_valid = 0; branch_valid = 0;
    mul_value = '0; ldst_value = '0; branch_value = '0;
    mul_rd = '0; ldst_rd = '0; branch_rd = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst_n = 0;
    cyc(); cyc();
    rst_n = 1;
    cyc();
    chk("reset_mask_alu_a", mask_alu_a, 16'h0000);
    chk("reset_wr_en_a", wr_en_a, 1'b0);
    chk("reset_wr_en_b", wr_en_b, 1'b0);
    chk("reset_stall_mul", wb_stall_mul, 1'b0);

    // ALU A round trip on r3
    dec_alu_a = mk_dec(4'd3, 1'b1); start_alu_a = 1;
    cyc();
    start_alu_a = 0;
    chk("t1_mask_set", mask_alu_a, 16'h0008);
    alu_a_valid = 1; alu_a_rd = 4'd3; alu_a_value = 32'hDEADBEEF;
    cyc();
    alu_a_valid = 0;
    chk("t1_wr_en_a", wr_en_a, 1'b1);
    chk("t1_wr_r_a", wr_r_a, 4'd3);
    chk("t1_wr_value_a", wr_value_a, 32'hDEADBEEF);
    chk("t1_mask_clr", mask_alu_a, 16'h0000);
    cyc();
    chk("t1_idle_en_a", wr_en_a, 1'b0);

    // branch beats mul
    dec_single = mk_dec(4'd2, 1'b1); start_mul = 1;
    cyc();
    start_mul = 0; dec_single = mk_dec(4'd7, 1'b1); start_branch = 1;
    cyc();
    start_branch = 0;
    chk("t2_mask_mul", mask_mul, 16'h0004);
    chk("t2_mask_branch", mask_branch, 16'h0080);
    mul_valid = 1; mul_rd = 4'd2; mul_value = 32'h0000_1234;
    branch_valid = 1; branch_rd = 4'd7; branch_value = 32'hB7B7_0007;
    #1;
    chk("t2_stall_branch", wb_stall_branch, 1'b0);
    chk("t2_stall_mul", wb_stall_mul, 1'b1);
    cyc();
    branch_valid = 0;
    #1;
    chk("t2_stall_mul_next", wb_stall_mul, 1'b0);
`ifdef CORE_WB_FORWARD_EN
    chk("t2_fwd_branch_en", wr_en_a, 1'b1);
    chk("t2_fwd_branch_r", wr_r_a, 4'd7);
`else
    chk("t2_branch_not_yet", wr_en_a, 1'b0);
`endif
    cyc();
    mul_valid = 0;
`ifdef CORE_WB_FORWARD_EN
    chk("t2_fwd_mul_r", wr_r_a, 4'd2);
`else
    chk("t2_branch_en", wr_en_a, 1'b1);
    chk("t2_branch_r", wr_r_a, 4'd7);
    chk("t2_branch_value", wr_value_a, 32'hB7B7_0007);
    chk("t2_mask_branch_clr", mask_branch, 16'h0000);
`endif
    cyc();
`ifndef CORE_WB_FORWARD_EN
    chk("t2_mul_r", wr_r_a, 4'd2);
`endif
    chk("t2_mask_mul_clr", mask_mul, 16'h0000);
    cyc();

    // ALUs busy, ldst fills the queue and then stalls
    alu_a_valid = 1; alu_a_rd = 4'd1; alu_a_value = 32'hA0;
    alu_b_valid = 1; alu_b_rd = 4'd2; alu_b_value = 32'hB0;
    ldst_valid = 1; ldst_rd = 4'd8; ldst_value = 32'h100;
    #1; chk("t3_stall_c0", wb_stall_ldst, 1'b0);
    cyc();
    ldst_rd = 4'd9; ldst_value = 32'h101;
    #1; chk("t3_stall_c1", wb_stall_ldst, 1'b0);
    cyc();
    ldst_rd = 4'd10; ldst_value = 32'h102;
    #1; chk("t3_stall_c2", wb_stall_ldst, 1'b1);
    cyc();
    #1; chk("t3_stall_c3", wb_stall_ldst, 1'b1);
    cyc();
    alu_a_valid = 0; alu_b_valid = 0;
    #1; chk("t3_stall_c4", wb_stall_ldst, 1'b0);
    cyc();
    ldst_valid = 0;
    chk("t3_d1_r", wr_r_a, 4'd8);
    chk("t3_d1_v", wr_value_a, 32'h100);
    chk("t3_d1_en_b", wr_en_b, 1'b0);
    cyc();
    chk("t3_d2_r", wr_r_a, 4'd9);
    cyc();
    chk("t3_d3_r", wr_r_a, 4'd10);
    chk("t3_d3_v", wr_value_a, 32'h102);
    cyc();
    chk("t3_idle", wr_en_a, 1'b0);

    // same-cycle set and clear of mul r5
    dec_single = mk_dec(4'd5, 1'b1); start_mul = 1;
    cyc();
    start_mul = 0;
    mul_valid = 1; mul_rd = 4'd5; mul_value = 32'h55;
`ifdef CORE_WB_FORWARD_EN
    start_mul = 1;
    cyc();
    start_mul = 0; mul_valid = 0;
`else
    cyc();
    mul_valid = 0; start_mul = 1;
    cyc();
    start_mul = 0;
`endif
    chk("t4_r5_write", wr_r_a, 4'd5);
    chk("t4_r5_pending", mask_mul, 16'h0020);
    mul_valid = 1;
    cyc();
    mul_valid = 0;
    cyc(); cyc();
    chk("t4_r5_done", mask_mul, 16'h0000);

    // fill the queue, then reset
    alu_a_valid = 1; alu_a_rd = 4'd1; alu_b_valid = 1; alu_b_rd = 4'd2;
    dec_single = mk_dec(4'd4, 1'b1); start_ldst = 1;
    dec_alu_a = mk_dec(4'd9, 1'b1); start_alu_a = 1;
    mul_valid = 1; mul_rd = 4'd11; mul_value = 32'h11;
    cyc();
    start_ldst = 0; start_alu_a = 0; mul_rd = 4'd12; mul_value = 32'h12;
    cyc();
    mul_rd = 4'd13;
    #1;
    chk("t5_full_stall", wb_stall_mul, 1'b1);
    chk("t5_mask_ldst", mask_ldst, 16'h0010);
    chk("t5_mask_alu_a", mask_alu_a, 16'h0200);
    rst_n = 0;
    cyc();
    rst_n = 1;
    idle_inputs();
    chk("t5_rst_mask_alu_a", mask_alu_a, 16'h0000);
    chk("t5_rst_mask_ldst", mask_ldst, 16'h0000);
    chk("t5_rst_en_a", wr_en_a, 1'b0);
    chk("t5_rst_en_b", wr_en_b, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t5_no_write_a", wr_en_a, 1'b0);
      chk("t5_no_write_b", wr_en_b, 1'b0);
    end

    // single-unit latency with idle ALUs
    mul_valid = 1; mul_rd = 4'd6; mul_value = 32'h66;
    cyc();
    mul_valid = 0;
`ifdef CORE_WB_FORWARD_EN
    chk("t6_lat1_en", wr_en_a, 1'b1);
    chk("t6_lat1_r", wr_r_a, 4'd6);
`else
    chk("t6_lat1_en", wr_en_a, 1'b0);
`endif
    cyc();
`ifndef CORE_WB_FORWARD_EN
    chk("t6_lat2_en", wr_en_a, 1'b1);
    chk("t6_lat2_r", wr_r_a, 4'd6);
`endif

    // ALU A busy: single result goes to port B
    cyc();
    alu_a_valid = 1; alu_a_rd = 4'd3; alu_a_value = 32'h33;
    mul_valid = 1; mul_rd = 4'd14; mul_value = 32'hE0E0;
    cyc();
    mul_valid = 0;
`ifdef CORE_WB_FORWARD_EN
    chk("t7_b_en", wr_en_b, 1'b1);
    chk("t7_b_r", wr_r_b, 4'd14);
`endif
    cyc();
`ifndef CORE_WB_FORWARD_EN
    chk("t7_b_en", wr_en_b, 1'b1);
    chk("t7_b_r", wr_r_b, 4'd14);
`endif
    cyc();
    alu_a_valid = 0;
    cyc(); cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
